// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read-port integer register file with a pending-write
// scoreboard and a hardware clear sweep that runs after reset or on request.
// Optional build macro: RF_BYPASS_EN (write-to-read forwarding in the same cycle).
module regfile_mp_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr_req,
   output logic                     rf_ready,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] ptr_reg, ptr_next;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              sb_reg [DEPTH];

   logic run;
   logic clr_ok;
   logic wr_ok;
   logic iss_ok;

   // Writes and issues only take effect in RUN, and a clear request in the
   // same cycle drops them; entry 0 is excluded when it is the hardwired zero.
   assign run      = (state_reg == RUN);
   assign clr_ok   = run && clr_req;
   assign wr_ok    = run && !clr_req && wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
   assign iss_ok   = run && !clr_req && iss_en && !((ZERO_REG != 0) && (iss_addr == '0));
   assign rf_ready = run;

   // State and sweep pointer register; reset restarts the sweep from entry 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= CLEAR;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
      end
   end

   // Next-state logic: sweep every entry once, then serve until a clear request.
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         CLEAR: begin
            ptr_next = ptr_reg + 1'b1;   // wraps to 0 after the last entry
            if (ptr_reg == ADDR_W'(DEPTH - 1))
               state_next = RUN;
         end
         RUN: begin
            if (clr_req) begin
               state_next = CLEAR;
               ptr_next   = '0;
            end
         end
         default: begin
            state_next = CLEAR;
            ptr_next   = '0;
         end
      endcase
   end

   // Storage array: the sweep zeroes one entry per cycle, RUN takes writeback.
   always_ff @(posedge clk) begin
      if (!run)
         mem[ptr_reg] <= '0;
      else if (wr_ok)
         mem[wr_addr] <= wr_data;
   end

   // One scoreboard bit per entry; a new issue outranks a same-cycle writeback.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sb
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               sb_reg[gi] <= 1'b0;
            else if (clr_ok)
               sb_reg[gi] <= 1'b0;
            else if (iss_ok && (iss_addr == ADDR_W'(gi)))
               sb_reg[gi] <= 1'b1;
            else if (wr_ok && (wr_addr == ADDR_W'(gi)))
               sb_reg[gi] <= 1'b0;
         end
      end
   endgenerate

   // Read ports: combinational lookup, masked to zero while the file is not ready.
   generate
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] ra;
         logic [DATA_W-1:0] dat;
         logic              bsy;

         assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

         // Select array contents, zero register, optional forwarding, sweep mask.
         always_comb begin
            dat = mem[ra];
            bsy = sb_reg[ra];
            if ((ZERO_REG != 0) && (ra == '0)) begin
               dat = '0;
               bsy = 1'b0;
            end
`ifdef RF_BYPASS_EN
            if (wr_ok && (ra == wr_addr)) begin
               dat = wr_data;
               bsy = iss_ok && (iss_addr == wr_addr);
            end
`else
`endif
            if (!run) begin
               dat = '0;
               bsy = 1'b0;
            end
         end

         assign rd_data[gi*DATA_W +: DATA_W] = dat;
         assign rd_busy[gi]                  = bsy;
      end
   endgenerate

endmodule
